// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer
// Multi-channel PWM engine driving the SB_RGBA_DRV RGBnPWM inputs. Each
// channel runs in one of four modes (off, static, blink, breathe). New
// settings arrive through a one-deep valid/ready write slot and are applied
// only at a PWM frame boundary, or at once while the engine is disabled.
//
// Ports:
//   hw_clk      system clock
//   rst_n       synchronous active-low reset
//   enable      run engine; low freezes counters and forces pwm_out low
//   prescale    tick divider reload, one PWM tick every prescale+1 clocks
//   cfg_valid   config write request
//   cfg_ready   config slot free
//   cfg_chan    target channel (values >= CHANNELS are accepted and dropped)
//   cfg_mode    00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE
//   cfg_duty    target duty
//   pwm_out     registered PWM drive, bit0 = RGB0PWM
//   frame_tick  one-clock pulse the clock after the PWM counter wraps
//
// Build option:
//   RGB_GAMMA_EN  square-law duty correction, adds one pipeline stage
//                 (pin latency 2 clocks instead of 1)
module rgb_pwm_sequencer #(
  parameter int  CHANNELS       = 3,
  parameter int  PWM_WIDTH      = 8,
  parameter int  PRESCALE_WIDTH = 16,
  parameter int  BLINK_FRAMES   = 64,
  localparam int CHAN_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      hw_clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CHAN_W-1:0]         cfg_chan,
  input  logic [1:0]                cfg_mode,
  input  logic [PWM_WIDTH-1:0]      cfg_duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      frame_tick
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam int                BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [CHAN_W:0]   CHAN_LIMIT = (CHAN_W + 1)'(CHANNELS);

  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic [PWM_WIDTH-1:0]      pwm_cnt;
  logic [BLINK_W-1:0]        blink_cnt;
  logic                      blink_phase;

  mode_e                     ch_mode  [CHANNELS];
  logic [PWM_WIDTH-1:0]      ch_duty  [CHANNELS];
  logic [PWM_WIDTH-1:0]      ch_level [CHANNELS];
  logic                      ch_down  [CHANNELS];

  logic                      pend_valid;
  logic [CHAN_W-1:0]         pend_chan;
  mode_e                     pend_mode;
  logic [PWM_WIDTH-1:0]      pend_duty;

  logic                      tick;
  logic                      wrap;
  logic                      accept;
  logic                      commit;
  logic [PWM_WIDTH-1:0]      eff [CHANNELS];
  logic                      frame_tick_q;
  logic [CHANNELS-1:0]       pwm_q;

  assign tick      = enable && (presc_cnt == prescale);
  assign wrap      = tick && (pwm_cnt == '1);
  assign cfg_ready = !pend_valid;
  // Out-of-range channels complete the handshake but never occupy the slot.
  assign accept    = cfg_valid && cfg_ready && ({1'b0, cfg_chan} < CHAN_LIMIT);
  // A disabled engine has no frames to wait for, so commit straight away.
  assign commit    = pend_valid && (wrap || !enable);

  // Timebase: prescaler, frame counter and the shared blink phase all freeze
  // while the engine is disabled.
  always_ff @(posedge hw_clk) begin
    if (!rst_n) begin
      presc_cnt    <= '0;
      pwm_cnt      <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= wrap;
      if (enable) begin
        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        if (tick) begin
          pwm_cnt <= pwm_cnt + 1'b1;
        end
        if (wrap) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end
    end
  end

  // One-deep write slot. Accept and commit never coincide because accept
  // needs the slot empty and commit needs it full.
  always_ff @(posedge hw_clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_chan  <= '0;
      pend_mode  <= MODE_OFF;
      pend_duty  <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_chan  <= cfg_chan;
      pend_mode  <= mode_e'(cfg_mode);
      pend_duty  <= cfg_duty;
    end else if (commit) begin
      pend_valid <= 1'b0;
    end
  end

  // Per-channel settings. A commit restarts the breathe ramp from zero; on
  // every frame wrap a breathing channel walks one step up to duty and back
  // down to zero.
  always_ff @(posedge hw_clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst_n) begin
        ch_mode[i]  <= MODE_OFF;
        ch_duty[i]  <= '0;
        ch_level[i] <= '0;
        ch_down[i]  <= 1'b0;
      end else if (commit && (pend_chan == CHAN_W'(i))) begin
        ch_mode[i]  <= pend_mode;
        ch_duty[i]  <= pend_duty;
        ch_level[i] <= '0;
        ch_down[i]  <= 1'b0;
      end else if (wrap && (ch_mode[i] == MODE_BREATHE)) begin
        if (ch_duty[i] == '0) begin
          ch_level[i] <= '0;
          ch_down[i]  <= 1'b0;
        end else if (!ch_down[i]) begin
          if (ch_level[i] < ch_duty[i]) begin
            ch_level[i] <= ch_level[i] + 1'b1;
            if ((ch_level[i] + 1'b1) == ch_duty[i]) begin
              ch_down[i] <= 1'b1;
            end
          end else begin
            ch_down[i] <= 1'b1;
          end
        end else begin
          if (ch_level[i] != '0) begin
            ch_level[i] <= ch_level[i] - 1'b1;
            if (ch_level[i] == PWM_WIDTH'(1)) begin
              ch_down[i] <= 1'b0;
            end
          end else begin
            ch_down[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Effective duty seen by the comparator for each channel.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      eff[i] = '0;
      case (ch_mode[i])
        MODE_STATIC:  eff[i] = ch_duty[i];
        MODE_BLINK:   eff[i] = blink_phase ? '0 : ch_duty[i];
        MODE_BREATHE: eff[i] = ch_level[i];
        default:      eff[i] = '0;
      endcase
    end
  end

`ifdef RGB_GAMMA_EN
  logic [PWM_WIDTH-1:0] gam_duty [CHANNELS];
  logic [PWM_WIDTH-1:0] cnt_d;
  logic                 en_d;

  // Square-law correction; full scale is kept at full scale so a constant-high
  // channel stays constant high.
  function automatic logic [PWM_WIDTH-1:0] gamma_map(input logic [PWM_WIDTH-1:0] e);
    logic [2*PWM_WIDTH-1:0] sq;
    sq = {{PWM_WIDTH{1'b0}}, e} * {{PWM_WIDTH{1'b0}}, e};
    if (e == '1) begin
      return '1;
    end
    return sq[2*PWM_WIDTH-1:PWM_WIDTH];
  endfunction

  // Corrected duty is registered together with the counter and enable so the
  // comparator sees a consistent snapshot one clock later.
  always_ff @(posedge hw_clk) begin
    if (!rst_n) begin
      cnt_d <= '0;
      en_d  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        gam_duty[i] <= '0;
      end
    end else begin
      cnt_d <= pwm_cnt;
      en_d  <= enable;
      for (int i = 0; i < CHANNELS; i++) begin
        gam_duty[i] <= gamma_map(eff[i]);
      end
    end
  end

  always_ff @(posedge hw_clk) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_q[i] <= en_d && ((gam_duty[i] == '1) || (cnt_d < gam_duty[i]));
      end
    end
  end
`else
  // All-ones duty is forced high so full scale has no one-tick gap per frame.
  always_ff @(posedge hw_clk) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_q[i] <= enable && ((eff[i] == '1) || (pwm_cnt < eff[i]));
      end
    end
  end
`endif

  assign pwm_out    = pwm_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb_rgb_pwm_sequencer
// Self-checking bench for rgb_pwm_sequencer. A frame/tick-count model predicts
// pwm_out, frame_tick and cfg_ready every clock; directed scenarios add
// literal per-frame on-count expectations. Honours RGB_GAMMA_EN.
module tb_rgb_pwm_sequencer;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int BF = 2;
  localparam int FRAME = 256;

`ifdef RGB_GAMMA_EN
  localparam int E64  = 16;
  localparam int E128 = 64;
  localparam int BREATHE_EXP [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
  localparam int E64  = 64;
  localparam int E128 = 128;
  localparam int BREATHE_EXP [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
`endif

  logic          hw_clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [15:0]   prescale;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_chan;
  logic [1:0]    cfg_mode;
  logic [W-1:0]  cfg_duty;
  logic [CH-1:0] pwm_out;
  logic          frame_tick;

  int vectors     = 0;
  int miscompares = 0;

  rgb_pwm_sequencer #(
    .CHANNELS      (CH),
    .PWM_WIDTH     (W),
    .PRESCALE_WIDTH(16),
    .BLINK_FRAMES  (BF)
  ) dut (
    .hw_clk    (hw_clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .prescale  (prescale),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_mode  (cfg_mode),
    .cfg_duty  (cfg_duty),
    .pwm_out   (pwm_out),
    .frame_tick(frame_tick)
  );

  always #5 hw_clk = ~hw_clk;

  // Model state: counts of enabled clocks, ticks and frames since reset, plus
  // the frame number at which each channel was last configured.
  bit      m_live = 0;
  longint  m_en_clks, m_ticks, m_frames;
  bit      m_pend;
  int      m_pchan, m_pmode, m_pduty;
  int      m_mode [CH];
  int      m_duty [CH];
  longint  m_cf   [CH];
  logic [CH-1:0] m_pipe;
  logic [CH-1:0] exp_pwm;
  logic          exp_ft;
  logic          exp_ready;

  int fcnt [16][CH];

  function automatic int effDuty(int mode, int duty, longint since, longint total);
    longint pos;
    case (mode)
      1: return duty;
      2: return (((total / BF) % 2) == 0) ? duty : 0;
      3: begin
        if (duty == 0) return 0;
        pos = since % (2 * duty);
        return (pos <= duty) ? int'(pos) : int'(2 * duty - pos);
      end
      default: return 0;
    endcase
  endfunction

  function automatic int gammaOf(int e);
`ifdef RGB_GAMMA_EN
    return (e == 255) ? 255 : ((e * e) >> 8);
`else
    return e;
`endif
  endfunction

  function automatic bit onAt(int e, int c);
    return (e == 255) || (c < e);
  endfunction

  task automatic modelStep();
    int cntr;
    bit tick, wrap, accept, commit;
    longint p;
    logic [CH-1:0] now;
    if (!rst_n) begin
      m_en_clks = 0; m_ticks = 0; m_frames = 0; m_pend = 0;
      m_pchan = 0; m_pmode = 0; m_pduty = 0;
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = 0; m_duty[i] = 0; m_cf[i] = 0;
      end
      m_pipe = '0; exp_pwm = '0; exp_ft = 0; exp_ready = 1; m_live = 1;
      return;
    end
    p      = longint'(prescale);
    cntr   = int'(m_ticks % FRAME);
    tick   = enable && ((m_en_clks % (p + 1)) == p);
    wrap   = tick && (cntr == FRAME - 1);
    for (int i = 0; i < CH; i++)
      now[i] = enable && onAt(gammaOf(effDuty(m_mode[i], m_duty[i], m_frames - m_cf[i], m_frames)), cntr);
`ifdef RGB_GAMMA_EN
    exp_pwm = m_pipe;
    m_pipe  = now;
`else
    exp_pwm = now;
`endif
    exp_ft = wrap;
    accept = cfg_valid && !m_pend && (int'(cfg_chan) < CH);
    commit = m_pend && (wrap || !enable);
    if (enable) m_en_clks++;
    if (tick)   m_ticks++;
    if (wrap)   m_frames++;
    if (commit) begin
      m_mode[m_pchan] = m_pmode;
      m_duty[m_pchan] = m_pduty;
      m_cf[m_pchan]   = m_frames;
      m_pend = 0;
    end
    if (accept) begin
      m_pend = 1; m_pchan = int'(cfg_chan); m_pmode = int'(cfg_mode); m_pduty = int'(cfg_duty);
    end
    exp_ready = !m_pend;
  endtask

  task automatic checkOutput();
    vectors++;
    if (pwm_out !== exp_pwm || frame_tick !== exp_ft || cfg_ready !== exp_ready) begin
      miscompares++;
      $display("[TB] FAIL cycle @%0t: pwm_out=%b exp %b, frame_tick=%b exp %b, cfg_ready=%b exp %b",
               $time, pwm_out, exp_pwm, frame_tick, exp_ft, cfg_ready, exp_ready);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial forever begin
    @(posedge hw_clk);
    modelStep();
  end

  initial forever begin
    @(negedge hw_clk);
    if (m_live) checkOutput();
  end

  task automatic doReset(input int n, input logic [15:0] p);
    rst_n = 0; enable = 0; prescale = p; cfg_valid = 0;
    repeat (n) @(negedge hw_clk);
    checkValue("reset_pwm_out", int'(pwm_out), 0);
    checkValue("reset_frame_tick", int'(frame_tick), 0);
    checkValue("reset_cfg_ready", int'(cfg_ready), 1);
    rst_n = 1;
  endtask

  // Holds cfg_valid until the slot is seen free at a falling edge, so the
  // following rising edge performs the accept.
  task automatic cfgWrite(input int chan, input int mode, input int duty, output bit ft_at_accept);
    int guard = 0;
    bit was;
    cfg_valid = 1; cfg_chan = 2'(chan); cfg_mode = 2'(mode); cfg_duty = 8'(duty);
    ft_at_accept = 0;
    do begin
      was = cfg_ready;
      ft_at_accept = frame_tick;
      @(negedge hw_clk);
      guard++;
    end while (!was && guard < 3000);
    cfg_valid = 0;
    if (!was) checkValue("cfg_accept_timeout", 0, 1);
  endtask

  task automatic measureFrames(input int n);
    int guard = 0;
    do begin
      @(negedge hw_clk);
      guard++;
    end while (!frame_tick && guard < 3000);
    if (!frame_tick) begin
      checkValue("frame_tick_timeout", 0, 1);
      return;
    end
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < CH; c++) fcnt[f][c] = 0;
      for (int k = 0; k < FRAME; k++) begin
        @(negedge hw_clk);
        for (int c = 0; c < CH; c++) fcnt[f][c] += int'(pwm_out[c]);
      end
    end
  endtask

  task automatic applyStimulus(input int cycles, input logic [15:0] p);
    doReset(2, p);
    enable = 1;
    for (int k = 0; k < cycles; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1;
        cfg_chan  = 2'($urandom_range(0, 3));
        cfg_mode  = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       cfg_duty = 8'd0;
          1:       cfg_duty = 8'hFF;
          2:       cfg_duty = 8'($urandom_range(1, 6));
          default: cfg_duty = 8'($urandom_range(0, 255));
        endcase
      end else begin
        cfg_valid = 0;
      end
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      rst_n = ($urandom_range(0, 4999) != 0);
      @(negedge hw_clk);
    end
    cfg_valid = 0; rst_n = 1; enable = 1;
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ft;
    int n, on_frames, off_frames;
    rst_n = 0; enable = 0; prescale = 0; cfg_valid = 0;
    cfg_chan = 0; cfg_mode = 0; cfg_duty = 0;

    $display("[TB] reset and single static write");
    doReset(3, 16'd0);
    enable = 1;
    cfgWrite(0, 1, 64, ft);
    measureFrames(1);
    checkValue("static64_ch0", fcnt[0][0], E64);
    checkValue("static64_ch1", fcnt[0][1], 0);
    checkValue("static64_ch2", fcnt[0][2], 0);

    $display("[TB] back-to-back writes, full scale and zero");
    cfgWrite(1, 1, 255, ft);
    cfgWrite(2, 1, 0, ft);
    checkValue("stall_release_at_frame", int'(ft), 1);
    measureFrames(3);
    for (int f = 0; f < 3; f++) begin
      checkValue("full_scale_ch1", fcnt[f][1], FRAME);
      checkValue("zero_ch2", fcnt[f][2], 0);
    end

    $display("[TB] breathe duty 3");
    cfgWrite(2, 3, 3, ft);
    measureFrames(8);
    for (int f = 0; f < 8; f++) checkValue("breathe_frame", fcnt[f][2], BREATHE_EXP[f]);

    $display("[TB] blink duty 128");
    cfgWrite(0, 2, 128, ft);
    measureFrames(8);
    on_frames = 0; off_frames = 0;
    for (int f = 0; f < 8; f++) begin
      if (fcnt[f][0] == E128) on_frames++;
      if (fcnt[f][0] == 0) off_frames++;
    end
    checkValue("blink_on_frames", on_frames, 4);
    checkValue("blink_off_frames", off_frames, 4);
    for (int f = 0; f < 6; f++) checkValue("blink_alternates", int'(fcnt[f][0] != fcnt[f+2][0]), 1);

    $display("[TB] frame_tick interval with prescale 2");
    doReset(2, 16'd2);
    enable = 1;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin @(negedge hw_clk); n++; end while (!frame_tick && n < 5000);
      if (r > 0) checkValue("frame_interval", n, 3 * FRAME);
    end

    $display("[TB] disabled commit and reset with pending write");
    doReset(2, 16'd0);
    enable = 1;
    cfgWrite(0, 1, 128, ft);
    enable = 0;
    repeat (2) @(negedge hw_clk);
    checkValue("disabled_commit_ready", int'(cfg_ready), 1);
    checkValue("disabled_pwm_low", int'(pwm_out), 0);
    enable = 1;
    measureFrames(1);
    checkValue("static128_ch0", fcnt[0][0], E128);
    cfgWrite(1, 1, 255, ft);
    doReset(1, 16'd0);
    enable = 1;
    measureFrames(2);
    for (int f = 0; f < 2; f++)
      checkValue("post_reset_all_off", fcnt[f][0] + fcnt[f][1] + fcnt[f][2], 0);

    $display("[TB] randomized traffic");
    applyStimulus(7000, 16'd0);
    applyStimulus(7000, 16'd1);
    applyStimulus(4000, 16'($urandom_range(0, 3)));
    repeat (4) @(negedge hw_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_sequencer.md
Name: rgb_pwm_sequencer

Overview:
- Parametrised multi-channel PWM engine that generates the per-channel PWM drive feeding the SB_RGBA_DRV RGBnPWM inputs.
- Replaces fixed tie-offs with runtime-programmable duty and mode per channel: off, static, blink and breathe.
- Configuration arrives over a valid/ready write port.
- Updates are committed only at PWM frame boundaries, so there are no output glitches.

Parameters:
- CHANNELS, 3, number of PWM channels (red, green, blue by default).
- PWM_WIDTH, 8, PWM counter and duty width; frame = 2^PWM_WIDTH ticks.
- PRESCALE_WIDTH, 16, width of the runtime prescaler reload.
- BLINK_FRAMES, 64, frames per blink half-period (on or off); must be ≥1.

Ports:
- hw_clk, input, 1, single system clock (internal oscillator domain).
- rst_n, input, 1, synchronous active-low reset.
- enable, input, 1, run engine; low holds counters and forces pwm_out to 0.
- prescale, input, PRESCALE_WIDTH, tick divider reload; one PWM tick every prescale+1 clocks.
- cfg_valid, input, 1, config write request.
- cfg_ready, output, 1, config slot free.
- cfg_chan, input, max(1,$clog2(CHANNELS)), target channel.
- cfg_mode, input, 2, 00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE.
- cfg_duty, input, PWM_WIDTH, target duty.
- pwm_out, output, CHANNELS, registered PWM, bit0 = RGB0PWM.
- frame_tick, output, 1, one-clock pulse on PWM counter wrap.

Behaviour:
- Reset (rst_n low at posedge hw_clk), all of the following cleared:
  - prescaler, PWM counter, blink counter, blink phase.
  - all per-channel mode (OFF), duty, breathe level and direction (up).
  - pending slot.
- Output values while in reset: pwm_out=0, frame_tick=0, cfg_ready=1.
- Prescaler:
  - Counts 0..prescale.
  - Emits a tick and reloads to 0 on the cycle it equals prescale; prescale=0 gives a tick every clock.
  - A prescale change takes effect at the next compare.
- PWM counter:
  - Increments on tick and wraps 2^PWM_WIDTH-1 -> 0.
  - frame_tick is asserted the clock after the wrap tick, for one clock.
- Config handshake:
  - Write accepted when cfg_valid && cfg_ready; captured into a single pending slot, and cfg_ready drops the next clock.
  - Pending write commits on the wrap tick; cfg_ready returns high the clock after.
  - If a wrap tick and an accept occur in the same clock, the new write waits for the next wrap.
  - cfg_chan ≥ CHANNELS: accepted and discarded; no pending set, cfg_ready stays 1.
  - Commit resets that channel's breathe level to 0 and direction to up.
- Effective duty e per channel:
  - OFF: 0.
  - STATIC: duty.
  - BLINK: duty while blink phase = 0, else 0.
    - Blink counter counts frames 0..BLINK_FRAMES-1; phase toggles on its wrap; shared by all channels.
  - BREATHE: level.
    - Each frame, level steps by 1 toward duty (up), then toward 0 (down).
    - Direction flips on reaching duty or 0.
    - duty=0 holds level at 0.
- Compare:
  - pwm_out[i] registered = (e == all-ones) ? 1 : (counter < e).
  - So duty 0 is constant low, all-ones is constant high, and intermediate values give e/2^PWM_WIDTH on-time.
  - One clock latency from counter to pin.
- enable low:
  - Prescaler, counter and blink/breathe state hold; pwm_out forced to 0 next clock; no frame_tick.
  - Pending writes commit immediately (next clock) rather than waiting for a wrap.
  - Rising enable resumes from the held counter.
- Reset mid-frame or with a write pending: the pending write is lost and all state returns to the reset values above.

Optional Feature:
- RGB_GAMMA_EN defined: effective duty passes through square-law correction, e' = (e*e) >> PWM_WIDTH, with e = all-ones mapped to all-ones. Adds one pipeline register, so pin latency is 2 clocks.
- Undefined: linear duty, 1-clock latency.

Test Plan:
- Reset, enable=1, prescale=0, write ch0 STATIC duty=64 -> after next wrap, pwm_out[0] high exactly 64 of 256 clocks per frame; ch1/ch2 stay 0.
- ch1 STATIC duty=8'hFF and ch2 duty=0 -> pwm_out[1] constant 1, pwm_out[2] constant 0 across 3 frames.
- Two back-to-back cfg_valid writes -> second stalled with cfg_ready=0 until the clock after the first wrap; both applied on consecutive frames.
- BLINK_FRAMES=2, ch0 BLINK duty=128 -> 2 frames at 50%, 2 frames off, repeating; frame_tick every 256×(prescale+1) clocks.
- ch2 BREATHE duty=3 -> per-frame on-counts 0,1,2,3,2,1,0,1…
- enable low mid-frame with a write pending, then rst_n low for 1 clock -> pwm_out=0, cfg_ready=1, all modes OFF; with RGB_GAMMA_EN, STATIC duty=128 yields 64 on-clocks per frame.
